morse_tx: RTL and testbench
===========================

MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 The block SHALL expose the parameter UNIT_CYCLES, default 12_500_000, giving the number of clk cycles in one Morse time unit (0.25 s at 50 MHz); legal range is 1 to 2^24.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 char_in  input  6  character code: 0-25 = A-Z, 26-35 = digits 0-9, 36 = word space, 37-63 = invalid.
REQ-005 char_valid  input  1  char_in is valid this cycle.
REQ-006 char_ready  output  1  block can accept a character; a transfer occurs on any cycle where char_valid and char_ready are both 1.
REQ-007 key_out  output  1  keyed signal (LED/buzzer); 1 = mark (tone on).
REQ-008 dot_out  output  1  high during every cycle of a dot mark.
REQ-009 dash_out  output  1  high during every cycle of a dash mark.
REQ-010 busy  output  1  high from the cycle after acceptance until char_ready re-asserts.

Function
REQ-011 The FSM SHALL have the states IDLE, MARK, ELEM_GAP, CHAR_GAP and WORD_GAP; char_ready SHALL be 1 only in IDLE.
REQ-012 On acceptance of a valid letter or digit, the code SHALL be looked up as length L (1-5) and pattern (MSB first, 1 = dash), and MARK SHALL be entered on the next cycle.
REQ-013 In MARK, key_out SHALL be high for exactly UNIT_CYCLES cycles for a dot or 3*UNIT_CYCLES cycles for a dash, with dot_out or dash_out high for the same cycles.
REQ-014 Between elements of one character, ELEM_GAP SHALL hold key_out low for exactly UNIT_CYCLES cycles.
REQ-015 After the last element, CHAR_GAP SHALL hold key_out low for exactly 3*UNIT_CYCLES cycles, then the FSM SHALL go to IDLE.
REQ-016 Code 36 SHALL enter WORD_GAP with key_out low for exactly 4*UNIT_CYCLES cycles, giving 7 units in total after the preceding CHAR_GAP, then the FSM SHALL go to IDLE.
REQ-017 Codes 37-63 SHALL be accepted and discarded; the FSM SHALL stay in IDLE with no output and no busy pulse.
REQ-018 Back-to-back characters SHALL be separated by exactly 3*UNIT_CYCLES+1 low cycles, because of the single IDLE cycle.
REQ-019 The character and its pattern SHALL be registered at acceptance; char_in changes while busy SHALL have no effect.
REQ-020 The unit counter SHALL be wide enough to count 4*UNIT_CYCLES-1 and SHALL reload on every state change; the element index SHALL count L down to 0.
REQ-021 key_out, dot_out and dash_out SHALL be registered outputs, glitch-free.
REQ-022 dot_out and dash_out SHALL never be high at the same time, and neither SHALL be high while key_out is 0.

Reset
REQ-023 While reset is high, the FSM SHALL be in IDLE; key_out, dot_out, dash_out and busy SHALL be 0; char_ready SHALL be 0; counters SHALL be cleared.
REQ-024 In the cycle after reset deasserts, char_ready SHALL be 1.
REQ-025 Reset asserted mid-character SHALL abort that character; key_out SHALL be 0 on the next cycle and the character SHALL not resume.

Structure
REQ-026 A shared package morse_pkg SHALL hold the FSM state enum, the character-code constants (CODE_SPACE = 36, CODE_MAX_VALID = 36) and the unit multipliers (DASH = 3, CHAR_GAP = 3, WORD_EXTRA = 4).
REQ-027 A combinational sub-module morse_rom SHALL map the 6-bit code to a 3-bit length, a 5-bit pattern and a valid flag.

Verification (UNIT_CYCLES = 4; acceptance edge = cycle 0)
REQ-028 'E' (code 4): key_out/dot_out high cycles 1-4; low cycles 5-16; char_ready = 1 at cycle 17.
REQ-029 'A' (code 0): dot high cycles 1-4; low 5-8; dash_out high 9-20; low 21-32; char_ready at 33.
REQ-030 Space (code 36): key_out low throughout; busy high cycles 1-16; char_ready at 17.
REQ-031 Invalid code 50: char_ready stays 1 and key_out/busy stay 0 for 20 cycles; next 'T' (code 19) gives key_out/dash_out high 12 cycles.
REQ-032 Reset high at cycle 6 during 'A': cycle 7 shows key_out = 0 and char_ready = 0; char_ready = 1 the cycle after reset drops; no further marks.
REQ-033 Stream "SOS" with char_valid held high: 3*4+1 = 13 low cycles between characters; dot/dash sequence ...---... is checked against a scoreboard.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter: FSM states, code constants,
// unit multipliers and the ROM entry layout.
package morse_pkg;
    localparam int unsigned CODE_W = 6;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned PAT_W  = 5;

    localparam logic [CODE_W-1:0] CODE_SPACE     = 6'd36;
    localparam logic [CODE_W-1:0] CODE_MAX_VALID = 6'd36;

    localparam int unsigned DASH       = 3;
    localparam int unsigned CHAR_GAP   = 3;
    localparam int unsigned WORD_EXTRA = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_ELEM_GAP,
        ST_CHAR_GAP,
        ST_WORD_GAP
    } morse_state_t;

    // Pattern is left-aligned: bit PAT_W-1 is the first element, 1 = dash.
    typedef struct packed {
        logic             valid;
        logic [LEN_W-1:0] len;
        logic [PAT_W-1:0] pattern;
    } morse_code_t;

    function automatic morse_code_t code_entry(input int unsigned len,
                                               input logic [PAT_W-1:0] pattern);
        morse_code_t e;
        e.valid   = 1'b1;
        e.len     = LEN_W'(len);
        e.pattern = pattern;
        return e;
    endfunction
endpackage

// File: rtl/morse_rom.sv
// Combinational lookup of a 6-bit character code into Morse length and pattern.
module morse_rom
    import morse_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic              valid_c,
    output logic [LEN_W-1:0]  len_c,
    output logic [PAT_W-1:0]  pattern_c
);
    morse_code_t entry;

    always_comb begin
        entry = '0;
        case (code)
            6'd0:  entry = code_entry(2, 5'b01000); // A .-
            6'd1:  entry = code_entry(4, 5'b10000); // B -...
            6'd2:  entry = code_entry(4, 5'b10100); // C -.-.
            6'd3:  entry = code_entry(3, 5'b10000); // D -..
            6'd4:  entry = code_entry(1, 5'b00000); // E .
            6'd5:  entry = code_entry(4, 5'b00100); // F ..-.
            6'd6:  entry = code_entry(3, 5'b11000); // G --.
            6'd7:  entry = code_entry(4, 5'b00000); // H ....
            6'd8:  entry = code_entry(2, 5'b00000); // I ..
            6'd9:  entry = code_entry(4, 5'b01110); // J .---
            6'd10: entry = code_entry(3, 5'b10100); // K -.-
            6'd11: entry = code_entry(4, 5'b01000); // L .-..
            6'd12: entry = code_entry(2, 5'b11000); // M --
            6'd13: entry = code_entry(2, 5'b10000); // N -.
            6'd14: entry = code_entry(3, 5'b11100); // O ---
            6'd15: entry = code_entry(4, 5'b01100); // P .--.
            6'd16: entry = code_entry(4, 5'b11010); // Q --.-
            6'd17: entry = code_entry(3, 5'b01000); // R .-.
            6'd18: entry = code_entry(3, 5'b00000); // S ...
            6'd19: entry = code_entry(1, 5'b10000); // T -
            6'd20: entry = code_entry(3, 5'b00100); // U ..-
            6'd21: entry = code_entry(4, 5'b00010); // V ...-
            6'd22: entry = code_entry(3, 5'b01100); // W .--
            6'd23: entry = code_entry(4, 5'b10010); // X -..-
            6'd24: entry = code_entry(4, 5'b10110); // Y -.--
            6'd25: entry = code_entry(4, 5'b11000); // Z --..
            6'd26: entry = code_entry(5, 5'b11111); // 0
            6'd27: entry = code_entry(5, 5'b01111); // 1
            6'd28: entry = code_entry(5, 5'b00111); // 2
            6'd29: entry = code_entry(5, 5'b00011); // 3
            6'd30: entry = code_entry(5, 5'b00001); // 4
            6'd31: entry = code_entry(5, 5'b00000); // 5
            6'd32: entry = code_entry(5, 5'b10000); // 6
            6'd33: entry = code_entry(5, 5'b11000); // 7
            6'd34: entry = code_entry(5, 5'b11100); // 8
            6'd35: entry = code_entry(5, 5'b11110); // 9
            default: entry = '0;
        endcase
    end

    assign valid_c   = entry.valid;
    assign len_c     = entry.len;
    assign pattern_c = entry.pattern;
endmodule

// File: rtl/morse_tx.sv
// Morse code transmitter: accepts one character code at a time and keys out its
// dots, dashes and inter-element / inter-character / word gaps in unit time.
module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 12_500_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              key_out,
    output logic              dot_out,
    output logic              dash_out,
    output logic              busy
);
    localparam int unsigned CNT_W = $clog2(WORD_EXTRA * UNIT_CYCLES);

    localparam logic [CNT_W-1:0] LD_UNIT = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_DASH = CNT_W'(DASH * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_CHAR = CNT_W'(CHAR_GAP * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_WORD = CNT_W'(WORD_EXTRA * UNIT_CYCLES - 1);

    morse_state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PAT_W-1:0] pat, pat_n;
    logic [LEN_W-1:0] elem, elem_n;

    logic             rom_valid;
    logic [LEN_W-1:0] rom_len;
    logic [PAT_W-1:0] rom_pat;
    logic             accept_c;
    logic             done_c;

    morse_rom u_rom (
        .code      (char_in),
        .valid_c   (rom_valid),
        .len_c     (rom_len),
        .pattern_c (rom_pat)
    );

    assign accept_c = char_valid && char_ready;
    assign done_c   = (cnt == '0);

    // Next-state, counter reload and element bookkeeping.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pat_n   = pat;
        elem_n  = elem;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    if (rom_valid) begin
                        state_n = ST_MARK;
                        pat_n   = rom_pat;
                        elem_n  = rom_len;
                        cnt_n   = rom_pat[PAT_W-1] ? LD_DASH : LD_UNIT;
                    end else if (char_in == CODE_SPACE) begin
                        state_n = ST_WORD_GAP;
                        cnt_n   = LD_WORD;
                    end
                end
            end
            ST_MARK: begin
                if (done_c) begin
                    elem_n = elem - LEN_W'(1);
                    pat_n  = {pat[PAT_W-2:0], 1'b0};
                    if (elem == LEN_W'(1)) begin
                        state_n = ST_CHAR_GAP;
                        cnt_n   = LD_CHAR;
                    end else begin
                        state_n = ST_ELEM_GAP;
                        cnt_n   = LD_UNIT;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_ELEM_GAP: begin
                if (done_c) begin
                    state_n = ST_MARK;
                    cnt_n   = pat[PAT_W-1] ? LD_DASH : LD_UNIT;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_CHAR_GAP, ST_WORD_GAP: begin
                if (done_c) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pat        <= '0;
            elem       <= '0;
            char_ready <= 1'b0;
            key_out    <= 1'b0;
            dot_out    <= 1'b0;
            dash_out   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pat        <= pat_n;
            elem       <= elem_n;
            char_ready <= (state_n == ST_IDLE);
            busy       <= (state_n != ST_IDLE);
            key_out    <= (state_n == ST_MARK);
            dot_out    <= (state_n == ST_MARK) && !pat_n[PAT_W-1];
            dash_out   <= (state_n == ST_MARK) && pat_n[PAT_W-1];
        end
    end
endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx: directed and random characters checked cycle
// by cycle against a timeline built from textual Morse patterns.
module tb_morse_tx;
    localparam int unsigned U = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] char_in;
    logic       char_valid;
    logic       char_ready, key_out, dot_out, dash_out, busy;

    int vectors = 0;
    int miscompares = 0;

    string MORSE [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
    };

    // Expected {key, dot, dash, busy} per cycle after acceptance.
    logic [3:0] exp_q[$];
    logic [4:0] obs;
    string      seen;
    logic       prev_dot = 1'b0, prev_dash = 1'b0;

    morse_tx #(.UNIT_CYCLES(U)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_out    (key_out),
        .dot_out    (dot_out),
        .dash_out   (dash_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic model(input int code);
        string m;
        byte   ch;
        exp_q.delete();
        if (code < 36) begin
            m = MORSE[code];
            for (int i = 0; i < m.len(); i++) begin
                ch = m[i];
                if (ch == 8'h2D) repeat (3 * U) exp_q.push_back(4'b1011);
                else             repeat (U)     exp_q.push_back(4'b1101);
                if (i == m.len() - 1) repeat (3 * U) exp_q.push_back(4'b0001);
                else                  repeat (U)     exp_q.push_back(4'b0001);
            end
        end else if (code == 36) begin
            repeat (4 * U) exp_q.push_back(4'b0001);
        end
    endtask

    task automatic sample();
        obs = {key_out, dot_out, dash_out, busy, char_ready};
        if (dot_out && !prev_dot)   seen = {seen, "."};
        if (dash_out && !prev_dash) seen = {seen, "-"};
        prev_dot  = dot_out;
        prev_dash = dash_out;
    endtask

    task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed key/dot/dash/busy/ready=%b expected %b", tag, o, e);
        end
    endtask

    // Sends one code at a negedge where char_ready is 1, then checks every cycle.
    task automatic run_char(input int code, input bit hold);
        model(code);
        char_valid = 1'b1;
        char_in    = 6'(code);
        @(posedge clk);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            sample();
            chk($sformatf("code%0d_cyc%0d", code, c + 1), obs, {exp_q[c], 1'b0});
            char_valid = hold ? 1'b1 : 1'($urandom_range(1));
            char_in    = 6'($urandom);
        end
        @(negedge clk);
        sample();
        chk($sformatf("code%0d_ready", code), obs, 5'b00001);
        char_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_in    = '0;
        repeat (3) @(negedge clk);
        sample();
        chk("reset_state", obs, 5'b00000);
        reset = 1'b0;
        @(negedge clk);
        sample();
        chk("ready_after_reset", obs, 5'b00001);

        run_char(4, 1'b0);   // E
        run_char(0, 1'b0);   // A
        run_char(36, 1'b0);  // word space

        // Invalid code is swallowed without any activity.
        char_valid = 1'b1;
        char_in    = 6'd50;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            sample();
            chk($sformatf("invalid_cyc%0d", c + 1), obs, 5'b00001);
        end
        run_char(19, 1'b0);  // T

        // Back-to-back SOS with char_valid held high.
        seen = "";
        run_char(18, 1'b1);
        run_char(14, 1'b1);
        run_char(18, 1'b1);
        vectors++;
        assert (seen == "...---...") else begin
            miscompares++;
            $error("FAIL sos_sequence: observed %s expected ...---...", seen);
        end

        // Reset in the middle of 'A' aborts it.
        model(0);
        char_valid = 1'b1;
        char_in    = 6'd0;
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            sample();
            chk($sformatf("abort_cyc%0d", c + 1), obs, {exp_q[c], 1'b0});
            char_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        sample();
        chk("abort_in_reset", obs, 5'b00000);
        reset = 1'b0;
        @(negedge clk);
        sample();
        chk("abort_ready", obs, 5'b00001);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            sample();
            chk($sformatf("abort_quiet%0d", c), obs, 5'b00001);
        end

        // Random codes, valid and invalid mixed.
        for (int n = 0; n < 12; n++) begin
            run_char(int'($urandom_range(0, 63)), 1'(n % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
